// File: rtl/lut_ff_pipe_array.sv
// CHANNELS lanes of a 2-input LUT, each followed by a DEPTH-stage clock-enabled
// register pipeline with a parallel valid pipeline and a saturating output-change counter.
module lut_ff_pipe_array #(
    parameter int         CHANNELS  = 3,
    parameter int         DEPTH     = 2,
    parameter logic [3:0] TRUTH     = 4'hE,
    parameter logic       RESET_VAL = 1'b0,
    parameter int         CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [CHANNELS-1:0]  a,
    input  logic [CHANNELS-1:0]  b,
    output logic [CHANNELS-1:0]  o,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] chg_cnt
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("lut_ff_pipe_array: CHANNELS must be within 1..16");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("lut_ff_pipe_array: DEPTH must be within 1..8");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("lut_ff_pipe_array: CNT_WIDTH must be at least 1");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CHANNELS-1:0]  f_s;
    logic [CHANNELS-1:0]  stage_r [DEPTH];
    logic [DEPTH-1:0]     valid_r;
    logic [CHANNELS-1:0]  last_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;

    // Per-lane truth-table lookup indexed by {b,a}
    always_comb begin
        f_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            f_s[i] = TRUTH[{b[i], a[i]}];
        end
    end

    // Data and valid pipelines; data stages capture every enabled cycle, valid marks real samples
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= {CHANNELS{RESET_VAL}};
            end
            valid_r <= '0;
        end else if (ce) begin
            stage_r[0] <= f_s;
            valid_r[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
                valid_r[k] <= valid_r[k-1];
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k];
            end
            valid_r <= valid_r;
        end
    end

    // Next counter value: bump on a valid output that differs from the previous one, pinned at max
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (valid_r[DEPTH-1] && (stage_r[DEPTH-1] != last_r) && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + 1'b1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Last-valid-output tracker and change counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= {CHANNELS{RESET_VAL}};
            cnt_r  <= '0;
        end else if (ce) begin
            if (valid_r[DEPTH-1]) begin
                last_r <= stage_r[DEPTH-1];
            end else begin
                last_r <= last_r;
            end
            cnt_r <= cnt_nxt_s;
        end else begin
            last_r <= last_r;
            cnt_r  <= cnt_r;
        end
    end

    assign o         = stage_r[DEPTH-1];
    assign out_valid = valid_r[DEPTH-1];
    assign chg_cnt   = cnt_r;

endmodule

// File: tb/tb_lut_ff_pipe_array.sv
// Directed bench for lut_ff_pipe_array: several parameterisations share one stimulus
// stream; each phase checks the instance it targets against hand-computed values.
module tb_lut_ff_pipe_array;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ce       = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] a        = 3'b000;
    logic [2:0] b        = 3'b000;

    int n_vec  = 0;
    int n_miss = 0;

    logic [2:0] o_or,  o_rv1,  o_xor,  o_and,  o_d4,  o_d3,  o_sat;
    logic       ov_or, ov_rv1, ov_xor, ov_and, ov_d4, ov_d3, ov_sat;
    logic [7:0] cnt_or, cnt_rv1, cnt_xor, cnt_and, cnt_d4, cnt_d3;
    logic [2:0] cnt_sat;

    always #5 clk = ~clk;

    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(2), .TRUTH(4'hE), .RESET_VAL(1'b0), .CNT_WIDTH(8)) u_or (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_or), .out_valid(ov_or), .chg_cnt(cnt_or));
    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(2), .TRUTH(4'hE), .RESET_VAL(1'b1), .CNT_WIDTH(8)) u_rv1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_rv1), .out_valid(ov_rv1), .chg_cnt(cnt_rv1));
    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(2), .TRUTH(4'h6), .RESET_VAL(1'b0), .CNT_WIDTH(8)) u_xor (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_xor), .out_valid(ov_xor), .chg_cnt(cnt_xor));
    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(2), .TRUTH(4'h8), .RESET_VAL(1'b0), .CNT_WIDTH(8)) u_and (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_and), .out_valid(ov_and), .chg_cnt(cnt_and));
    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(4), .TRUTH(4'hA), .RESET_VAL(1'b0), .CNT_WIDTH(8)) u_d4 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_d4), .out_valid(ov_d4), .chg_cnt(cnt_d4));
    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(3), .TRUTH(4'hA), .RESET_VAL(1'b0), .CNT_WIDTH(8)) u_d3 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_d3), .out_valid(ov_d3), .chg_cnt(cnt_d3));
    lut_ff_pipe_array #(.CHANNELS(3), .DEPTH(2), .TRUTH(4'hA), .RESET_VAL(1'b0), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .o(o_sat), .out_valid(ov_sat), .chg_cnt(cnt_sat));

    // Lane k of cycle j sees {b,a} combo (j+k)%4, so every lane walks all four combos
    logic [2:0] sw_a    [4] = '{3'b010, 3'b101, 3'b010, 3'b101};
    logic [2:0] sw_b    [4] = '{3'b100, 3'b110, 3'b011, 3'b001};
    logic [2:0] exp_xor [4] = '{3'b110, 3'b011, 3'b001, 3'b100};
    logic [2:0] exp_and [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
    logic [2:0] seq_a   [4] = '{3'b000, 3'b001, 3'b001, 3'b000};
    logic [2:0] d4_a    [4] = '{3'b001, 3'b010, 3'b011, 3'b100};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] va, input logic [2:0] vb, input logic vv);
        a        = va;
        b        = vb;
        in_valid = vv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b1;
        drive(3'b000, 3'b000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values for both RESET_VAL settings
        do_reset();
        check("rst_o_rv0",    8'(o_or),    8'h00);
        check("rst_ov_rv0",   8'(ov_or),   8'h00);
        check("rst_cnt_rv0",  8'(cnt_or),  8'h00);
        check("rst_o_rv1",    8'(o_rv1),   8'h07);
        check("rst_ov_rv1",   8'(ov_rv1),  8'h00);
        check("rst_cnt_rv1",  8'(cnt_rv1), 8'h00);

        // OR latency: one valid sample, visible exactly one cycle, two cycles later
        drive(3'b001, 3'b100, 1'b1);
        tick();
        check("or_ov_early",  8'(ov_or),   8'h00);
        drive(3'b000, 3'b000, 1'b0);
        tick();
        check("or_o",         8'(o_or),    8'h05);
        check("or_ov",        8'(ov_or),   8'h01);
        tick();
        check("or_ov_after",  8'(ov_or),   8'h00);
        check("or_cnt",       8'(cnt_or),  8'h01);

        // Truth-table sweep, XOR and AND
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(sw_a[k], sw_b[k], 1'b1);
            else       drive(3'b000, 3'b000, 1'b0);
            tick();
            if (k >= 1 && k <= 4) begin
                check("sweep_xor_o",  8'(o_xor),  8'(exp_xor[k-1]));
                check("sweep_xor_ov", 8'(ov_xor), 8'h01);
                check("sweep_and_o",  8'(o_and),  8'(exp_and[k-1]));
            end
        end
        check("sweep_xor_cnt", 8'(cnt_xor), 8'h04);
        check("sweep_and_cnt", 8'(cnt_and), 8'h03);

        // XOR lane-0 sequence 0,1,1,0 gives two changes
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(seq_a[k], 3'b000, 1'b1);
            else       drive(3'b000, 3'b000, 1'b0);
            tick();
        end
        check("xor_seq_cnt", 8'(cnt_xor), 8'h02);

        // Clock-enable stall on DEPTH=4; junk offered during the stall must be ignored
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(d4_a[k], 3'b000, 1'b1);
            tick();
        end
        check("stall_o0",    8'(o_d4),   8'h01);
        check("stall_ov0",   8'(ov_d4),  8'h01);
        check("stall_cnt0",  8'(cnt_d4), 8'h00);
        drive(3'b000, 3'b000, 1'b0);
        tick();
        check("stall_o1",    8'(o_d4),   8'h02);
        check("stall_cnt1",  8'(cnt_d4), 8'h01);
        ce = 1'b0;
        drive(3'b111, 3'b111, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold_o",   8'(o_d4),   8'h02);
            check("stall_hold_ov",  8'(ov_d4),  8'h01);
            check("stall_hold_cnt", 8'(cnt_d4), 8'h01);
        end
        ce = 1'b1;
        drive(3'b000, 3'b000, 1'b0);
        tick();
        check("stall_o2",    8'(o_d4),   8'h03);
        check("stall_cnt2",  8'(cnt_d4), 8'h02);
        tick();
        check("stall_o3",    8'(o_d4),   8'h04);
        check("stall_ov3",   8'(ov_d4),  8'h01);
        check("stall_cnt3",  8'(cnt_d4), 8'h03);
        tick();
        check("stall_ov_end",  8'(ov_d4),  8'h00);
        check("stall_cnt_end", 8'(cnt_d4), 8'h04);
        tick();
        check("stall_no_dup",  8'(ov_d4),  8'h00);

        // Reset mid-stream on DEPTH=3, asserted with ce low
        do_reset();
        drive(3'b011, 3'b000, 1'b1);
        tick();
        drive(3'b110, 3'b000, 1'b1);
        tick();
        rst = 1'b1;
        ce  = 1'b0;
        drive(3'b000, 3'b000, 1'b0);
        tick();
        check("mid_rst_o",   8'(o_d3),   8'h00);
        check("mid_rst_ov",  8'(ov_d3),  8'h00);
        rst = 1'b0;
        ce  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_flush_ov", 8'(ov_d3), 8'h00);
        end
        check("mid_cnt",     8'(cnt_d3), 8'h00);
        drive(3'b101, 3'b000, 1'b1);
        tick();
        check("mid_new_ov1", 8'(ov_d3),  8'h00);
        drive(3'b000, 3'b000, 1'b0);
        tick();
        check("mid_new_ov2", 8'(ov_d3),  8'h00);
        tick();
        check("mid_new_o",   8'(o_d3),   8'h05);
        check("mid_new_ov",  8'(ov_d3),  8'h01);
        tick();
        check("mid_new_cnt", 8'(cnt_d3), 8'h01);

        // Counter saturation with CNT_WIDTH=3 over ten alternating outputs
        do_reset();
        for (int k = 0; k < 13; k++) begin
            if (k < 10) drive(((k % 2) == 0) ? 3'b111 : 3'b000, 3'b000, 1'b1);
            else        drive(3'b000, 3'b000, 1'b0);
            tick();
            if (k == 7) check("sat_cnt6",  8'(cnt_sat), 8'h06);
            if (k == 8) check("sat_cnt7",  8'(cnt_sat), 8'h07);
        end
        check("sat_hold", 8'(cnt_sat), 8'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lut_ff_pipe_array.md
Name: lut_ff_pipe_array

Overview:
- Parametrised successor to the single-LUT/single-FF feature test.
- CHANNELS independent 2-input LUT functions, each defined by a 4-bit truth table.
- Each LUT output is registered through a DEPTH-stage clock-enabled FF pipeline, with a matching valid pipeline.
- An output-change counter exercises FF feedback and carry logic.
- Sits between IB/OB pad wrappers in architecture LUT/FF placement and routing tests.

Parameters:
- CHANNELS, 3, number of independent LUT+pipeline lanes (1..16).
- DEPTH, 2, register stages per lane (1..8); also the latency.
- TRUTH, 4'hE, truth table shared by all lanes. Output = TRUTH[{b,a}]; 4'hE = OR, 4'h8 = AND, 4'h6 = XOR.
- RESET_VAL, 1'b0, value every data pipeline bit and the last-output register take on reset.
- CNT_WIDTH, 8, width of the change counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable for all pipeline, valid and counter state.
- in_valid  input  1  qualifies a/b this cycle.
- a  input  CHANNELS  LUT input 0, one bit per lane.
- b  input  CHANNELS  LUT input 1, one bit per lane.
- o  output  CHANNELS  final pipeline stage data.
- out_valid  output  1  final valid stage.
- chg_cnt  output  CNT_WIDTH  saturating count of valid output changes.

Behaviour:
- LUT: f[i] = TRUTH[{b[i],a[i]}], purely combinational. No other logic between the LUT and stage 0.
- Pipeline, per lane: stage[0] <= f; stage[k] <= stage[k-1]. Valid pipeline: v[0] <= in_valid; v[k] <= v[k-1].
  - Stages update only on cycles with ce=1.
  - o = stage[DEPTH-1]; out_valid = v[DEPTH-1].
- Latency: sample accepted at edge n (ce=1) appears on o/out_valid after DEPTH ce-high edges. With ce held high, it is visible after edge n+DEPTH-1 settles, i.e. DEPTH cycles after presentation.
- ce=0: every register holds (data, valid, last-output, counter). No bubble is inserted and no data is lost.
- Data stages always capture f regardless of in_valid. Only the valid pipeline marks meaningful samples.
- Change counter:
  - Internal last_o register (CHANNELS bits) is updated on each ce=1 edge where out_valid=1: last_o <= o.
  - On the same edge, if out_valid=1 and o != last_o, chg_cnt increments by 1.
  - chg_cnt saturates at 2^CNT_WIDTH-1 and does not wrap.
- Reset:
  - rst=1 at an edge: all data stages <= {CHANNELS{RESET_VAL}}, all valid stages <= 0, last_o <= {CHANNELS{RESET_VAL}}, chg_cnt <= 0.
  - rst dominates ce; reset applies even with ce=0.
  - Reset mid-stream discards all in-flight samples. out_valid is 0 from the cycle after the reset edge until DEPTH ce-high edges after the first new in_valid.
- Outputs after reset: o = RESET_VAL replicated, out_valid = 0, chg_cnt = 0.
- Simultaneous events:
  - in_valid with ce=0 is ignored (not captured).
  - Counter increment and saturation are evaluated on the same edge; at max, it stays at max.
- No combinational path from inputs to outputs; all outputs are registered.
- Out-of-range parameters are an elaboration error.

Test Plan:
- Reset values: CHANNELS=3, DEPTH=2, RESET_VAL=0, hold rst 2 cycles -> o=3'b000, out_valid=0, chg_cnt=0. Repeat with RESET_VAL=1 -> o=3'b111.
- OR latency: TRUTH=4'hE, ce=1. Drive a=3'b001, b=3'b100, in_valid=1 for one cycle, then in_valid=0 -> o=3'b101 with out_valid=1 exactly 2 cycles later, for 1 cycle. chg_cnt=1.
- Truth-table sweep: TRUTH=4'h6 (XOR) and 4'h8 (AND). Apply all 4 {b,a} combos on every lane -> o matches TRUTH bit per combo after DEPTH cycles. With TRUTH=4'h6, sequence 0,1,1,0 on lane 0 with b=0 -> chg_cnt=2.
- Clock-enable stall: DEPTH=4, stream 4 distinct valid samples, drop ce for 3 cycles mid-stream -> o, out_valid and chg_cnt frozen during the stall; the sample order is preserved and none is lost or duplicated.
- Reset mid-operation: DEPTH=3, assert rst while 2 valid samples are in flight -> neither emerges, chg_cnt=0. The next sample arrives 3 cycles after presentation.
- Counter saturation: CNT_WIDTH=3, alternate o between 3'b000 and 3'b111 for 10 valid outputs -> chg_cnt reaches 7 and holds 7.
